adaptive_mode_scheduler: RTL and testbench



---
 rtl/adaptive_mode_scheduler.sv | 123 ++++++++++++
 tb/tb_adaptive_mode_scheduler.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/adaptive_mode_scheduler.sv
// Chooses LowPower/HighPerf mode from windowed issue activity with hysteresis and SW override.
// Latency: decision at cycle T -> issue stalled T+1..T+DRAIN_CYCLES+1, new mode at T+DRAIN_CYCLES+2.
// Backpressure: issue_stall holds upstream issue for the whole drain/switch sequence.
module adaptive_mode_scheduler #(
    parameter int WINDOW_LEN   = 64,
    parameter int HI_THRESH    = 48,
    parameter int LO_THRESH    = 16,
    parameter int HOLD_WINDOWS = 2,
    parameter int DRAIN_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       valid_in,
    input  logic       mode_req_en,
    input  logic       mode_req,
    output logic       mode,
    output logic       issue_stall,
    output logic       switching,
    output logic [7:0] switch_count
);

    localparam int AW = $clog2(WINDOW_LEN + 1);
    localparam int WW = (WINDOW_LEN > 1) ? $clog2(WINDOW_LEN) : 1;
    localparam int SW = $clog2(HOLD_WINDOWS + 1);
    localparam int DW = $clog2(DRAIN_CYCLES + 1);

    typedef enum logic [1:0] {LP_RUN, HP_RUN, DRAIN, SWITCH} state_t;

    state_t        state;
    logic [WW-1:0] win_cnt;
    logic [AW-1:0] act_cnt;
    logic [SW-1:0] streak;
    logic [DW-1:0] drain_cnt;

    logic [AW-1:0] act_total;
    logic [SW-1:0] streak_inc;
    logic          win_end;
    logic          busy;
    logic          idle;
    logic          qualify;

    // The evaluation cycle's own valid_in counts toward its window.
    assign act_total  = act_cnt + AW'(valid_in);
    assign win_end    = (win_cnt == WW'(WINDOW_LEN - 1));
    assign busy       = (act_total >= AW'(HI_THRESH));
    assign idle       = (act_total <= AW'(LO_THRESH));
    assign qualify    = (state == LP_RUN) ? busy : idle;
    assign streak_inc = streak + SW'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= LP_RUN;
            win_cnt      <= '0;
            act_cnt      <= '0;
            streak       <= '0;
            drain_cnt    <= '0;
            mode         <= 1'b0;
            issue_stall  <= 1'b0;
            switching    <= 1'b0;
            switch_count <= '0;
        end else begin
            case (state)
                LP_RUN, HP_RUN: begin
                    if (mode_req_en) begin
                        // Override freezes the measurement so a later auto decision starts fresh.
                        win_cnt <= '0;
                        act_cnt <= '0;
                        streak  <= '0;
                        if (mode_req != mode) begin
                            state       <= DRAIN;
                            drain_cnt   <= '0;
                            issue_stall <= 1'b1;
                            switching   <= 1'b1;
                        end
                    end else if (win_end) begin
                        win_cnt <= '0;
                        act_cnt <= '0;
                        if (qualify) begin
                            if (streak_inc == SW'(HOLD_WINDOWS)) begin
                                state       <= DRAIN;
                                drain_cnt   <= '0;
                                streak      <= '0;
                                issue_stall <= 1'b1;
                                switching   <= 1'b1;
                            end else begin
                                streak <= streak_inc;
                            end
                        end else begin
                            streak <= '0;
                        end
                    end else begin
                        win_cnt <= win_cnt + WW'(1);
                        act_cnt <= act_total;
                    end
                end
                DRAIN: begin
                    if (drain_cnt == DW'(DRAIN_CYCLES - 1)) begin
                        state     <= SWITCH;
                        drain_cnt <= '0;
                    end else begin
                        drain_cnt <= drain_cnt + DW'(1);
                    end
                end
                SWITCH: begin
                    mode        <= ~mode;
                    state       <= mode ? LP_RUN : HP_RUN;
                    issue_stall <= 1'b0;
                    switching   <= 1'b0;
                    win_cnt     <= '0;
                    act_cnt     <= '0;
                    streak      <= '0;
                    if (switch_count != 8'hFF) begin
                        switch_count <= switch_count + 8'd1;
                    end
                end
                default: begin
                    state <= LP_RUN;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_adaptive_mode_scheduler.sv
// Directed bench for adaptive_mode_scheduler; mode changes are checked against a queue of expected switches.
module tb_adaptive_mode_scheduler;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       valid_in = 1'b0;
    logic       mode_req_en = 1'b0;
    logic       mode_req = 1'b0;
    logic       mode;
    logic       issue_stall;
    logic       switching;
    logic [7:0] switch_count;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic last_mode = 1'b0;

    typedef struct {
        logic m;
        int   cnt;
        int   at;
    } exp_t;
    exp_t sb[$];

    adaptive_mode_scheduler #(
        .WINDOW_LEN  (8),
        .HI_THRESH   (6),
        .LO_THRESH   (2),
        .HOLD_WINDOWS(2),
        .DRAIN_CYCLES(3)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .valid_in    (valid_in),
        .mode_req_en (mode_req_en),
        .mode_req    (mode_req),
        .mode        (mode),
        .issue_stall (issue_stall),
        .switching   (switching),
        .switch_count(switch_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Scoreboard: every mode change must match the oldest queued expectation.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("switching_implies_stall", (!switching || issue_stall), 1);
            if (mode !== last_mode) begin
                chk("unexpected_mode_change", (sb.size() != 0), 1);
                if (sb.size() != 0) begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("sb_mode", mode, e.m);
                    chk("sb_switch_count", switch_count, e.cnt);
                    chk("sb_change_cycle", cyc, e.at);
                end
            end
        end
        last_mode = mode;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic m, input int cnt, input int at);
        exp_t e;
        e.m = m;
        e.cnt = cnt;
        e.at = at;
        sb.push_back(e);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        valid_in = 1'b0;
        mode_req_en = 1'b0;
        mode_req = 1'b0;
        #1;
        chk("rst_mode", mode, 0);
        chk("rst_issue_stall", issue_stall, 0);
        chk("rst_switching", switching, 0);
        chk("rst_switch_count", switch_count, 0);
        repeat (3) step();
        rst_n = 1'b1;
    endtask

    // Drive one cycle's inputs and check the stall window [lo,hi] in cycle numbers.
    task automatic drive_cycle(input logic v, input logic en, input logic req,
                               input int lo, input int hi);
        valid_in = v;
        mode_req_en = en;
        mode_req = req;
        chk("issue_stall", issue_stall, (cyc >= lo && cyc <= hi));
        chk("switching", switching, (cyc >= lo && cyc <= hi));
        step();
    endtask

    task automatic window(input int n, input int lo, input int hi);
        for (int i = 0; i < 8; i++) drive_cycle(i < n, 1'b0, 1'b0, lo, hi);
    endtask

    initial begin
        // Reset then 40 idle cycles: nothing moves.
        do_reset();
        repeat (40) begin
            chk("idle_mode", mode, 0);
            chk("idle_switch_count", switch_count, 0);
            drive_cycle(1'b0, 1'b0, 1'b0, -1, -1);
        end

        // Continuous activity: second window evaluates at 15, new mode at 20.
        do_reset();
        push_exp(1'b1, 1, 20);
        while (cyc < 22) drive_cycle(1'b1, 1'b0, 1'b0, 16, 19);
        chk("up_mode", mode, 1);
        chk("up_switch_count", switch_count, 1);

        // HP windows 20..27 (2 active, idle boundary) and 28..35 idle: down-switch at 40.
        push_exp(1'b0, 2, 40);
        while (cyc < 42) drive_cycle(1'b0, 1'b0, 1'b0, 36, 39);
        chk("down_mode", mode, 0);
        chk("down_switch_count", switch_count, 2);

        // Hysteresis: alternating busy/non-busy never switches; two windows of 6 do.
        do_reset();
        push_exp(1'b1, 1, 68);
        for (int w = 0; w < 6; w++) window((w % 2 == 0) ? 7 : 3, 64, 67);
        window(6, 64, 67);
        window(6, 64, 67);
        while (cyc < 70) drive_cycle(1'b0, 1'b0, 1'b0, 64, 67);
        chk("hyst_mode", mode, 1);

        // Override up at cycle 2; counters stay frozen while override is held in HP.
        do_reset();
        drive_cycle(1'b0, 1'b0, 1'b0, 3, 6);
        drive_cycle(1'b0, 1'b0, 1'b0, 3, 6);
        push_exp(1'b1, 1, 7);
        while (cyc < 12) drive_cycle(1'b1, 1'b1, 1'b1, 3, 6);
        chk("ovr_mode", mode, 1);
        push_exp(1'b0, 2, 32);
        while (cyc < 34) drive_cycle(1'b0, 1'b0, 1'b0, 28, 31);

        // Busy windows ending at 39 and 47; override to current mode at 47 must win and clear streak.
        while (cyc < 47) drive_cycle(1'b1, 1'b0, 1'b0, -1, -1);
        drive_cycle(1'b1, 1'b1, 1'b0, -1, -1);
        while (cyc < 56) drive_cycle(1'b1, 1'b0, 1'b0, -1, -1);
        while (cyc < 66) drive_cycle(1'b0, 1'b0, 1'b0, -1, -1);
        chk("ovr_same_cycle_mode", mode, 0);
        chk("ovr_same_cycle_count", switch_count, 2);

        // Reset during the second drain cycle aborts the switch.
        do_reset();
        drive_cycle(1'b0, 1'b1, 1'b1, 1, 3);
        drive_cycle(1'b0, 1'b1, 1'b1, 1, 3);
        chk("drain2_stall", issue_stall, 1);
        rst_n = 1'b0;
        mode_req_en = 1'b0;
        #1;
        chk("abort_mode", mode, 0);
        chk("abort_issue_stall", issue_stall, 0);
        chk("abort_switching", switching, 0);
        chk("abort_switch_count", switch_count, 0);
        repeat (2) step();
        rst_n = 1'b1;
        repeat (20) drive_cycle(1'b0, 1'b0, 1'b0, -1, -1);
        chk("post_abort_mode", mode, 0);
        chk("post_abort_count", switch_count, 0);

        chk("sb_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
